// File: rtl/alu_pkg.sv
// Shared encodings for the ALU and the execute sequencer that drives it.
package alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD = 3'b000,
        ALU_SUB = 3'b001,
        ALU_XOR = 3'b010,
        ALU_SLT = 3'b011,
        ALU_BLT = 3'b100,
        ALU_BGE = 3'b101
    } alu_cntrl_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_XOR  = 3'd2,
        OP_SLT  = 3'd3,
        OP_BLT  = 3'd4,
        OP_BGE  = 3'd5,
        OP_MUL  = 3'd6,
        OP_RSVD = 3'd7
    } seq_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_RESP = 2'd3
    } seq_state_e;

    function automatic logic is_branch_op(input seq_op_e op);
        return (op == OP_BLT) || (op == OP_BGE);
    endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// Multi-cycle execute controller in front of the combinational ALU; adds a
// shift-add multiply that reuses the ALU adder for WIDTH iterations.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [2:0]              req_op,
    input  logic signed [WIDTH-1:0] req_a,
    input  logic signed [WIDTH-1:0] req_b,
    output logic [WIDTH-1:0]        alu_in1,
    output logic [WIDTH-1:0]        alu_in2,
    output logic [2:0]              alu_cntrl,
    output logic                    alu_br_en,
    input  logic [WIDTH-1:0]        alu_result,
    input  logic                    alu_br,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [WIDTH-1:0]        rsp_data,
    output logic                    rsp_taken
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    seq_state_e              state;
    seq_op_e                 op_q;
    logic signed [WIDTH-1:0] a_q;
    logic signed [WIDTH-1:0] b_q;
    logic signed [WIDTH-1:0] acc;
    logic signed [WIDTH-1:0] mcand;
    logic [WIDTH-1:0]        mplier;
    logic [CNT_W-1:0]        cnt;
    logic signed [WIDTH-1:0] acc_next;

    assign req_ready = rst_n && (state == ST_IDLE);

    // ALU inputs decode purely from registered state so they are stable all cycle.
    always_comb begin
        alu_in1   = '0;
        alu_in2   = '0;
        alu_cntrl = ALU_ADD;
        alu_br_en = 1'b0;
        case (state)
            ST_EXEC: begin
                alu_in1   = a_q;
                alu_in2   = b_q;
                alu_cntrl = op_q;
                alu_br_en = is_branch_op(op_q);
            end
            ST_MUL: begin
                alu_in1   = acc;
                alu_in2   = mcand;
                alu_cntrl = ALU_ADD;
            end
            default: ;
        endcase
    end

    assign acc_next = mplier[0] ? $signed(alu_result) : acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            op_q      <= OP_ADD;
            a_q       <= '0;
            b_q       <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_taken <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        op_q <= seq_op_e'(req_op);
                        a_q  <= req_a;
                        b_q  <= req_b;
                        if (seq_op_e'(req_op) == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= req_a;
                            mplier <= req_b;
                            cnt    <= '0;
                            state  <= ST_MUL;
                        end else begin
                            state <= ST_EXEC;
                        end
                    end
                end
                ST_EXEC: begin
                    rsp_data  <= alu_result;
                    rsp_taken <= is_branch_op(op_q) & alu_br;
                    rsp_valid <= 1'b1;
                    state     <= ST_RESP;
                end
                ST_MUL: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Fixed latency: the last add lands straight in the response register.
                    if (cnt == CNT_LAST) begin
                        rsp_data  <= acc_next;
                        rsp_taken <= 1'b0;
                        rsp_valid <= 1'b1;
                        state     <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer with a behavioural sibling ALU and a response scoreboard.
module tb_alu_op_sequencer;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               req_valid;
    logic               req_ready;
    logic [2:0]         req_op;
    logic signed [31:0] req_a;
    logic signed [31:0] req_b;
    logic [31:0]        alu_in1;
    logic [31:0]        alu_in2;
    logic [2:0]         alu_cntrl;
    logic               alu_br_en;
    logic [31:0]        alu_result;
    logic               alu_br;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [31:0]        rsp_data;
    logic               rsp_taken;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] data;
        logic        taken;
        int          lat;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    alu_op_sequencer #(.WIDTH(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .alu_in1    (alu_in1),
        .alu_in2    (alu_in2),
        .alu_cntrl  (alu_cntrl),
        .alu_br_en  (alu_br_en),
        .alu_result (alu_result),
        .alu_br     (alu_br),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_data   (rsp_data),
        .rsp_taken  (rsp_taken)
    );

    // Sibling ALU model
    always_comb begin
        alu_result = '0;
        alu_br     = 1'b0;
        case (alu_cntrl)
            3'b000: alu_result = alu_in1 + alu_in2;
            3'b001: alu_result = alu_in1 - alu_in2;
            3'b010: alu_result = alu_in1 ^ alu_in2;
            3'b011: alu_result = ($signed(alu_in1) < $signed(alu_in2)) ? 32'd1 : 32'd0;
            3'b100: alu_br = alu_br_en & ($signed(alu_in1) < $signed(alu_in2));
            3'b101: alu_br = alu_br_en & ($signed(alu_in1) >= $signed(alu_in2));
            default: ;
        endcase
    end

    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] ed, input logic et, input int el);
        int n;
        exp_t e;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL send_accept: req_ready=%0b required 1", req_ready);
        else n_pass++;
        @(posedge clk);
        #1 req_valid = 1'b0;
        e.data = ed; e.taken = et; e.lat = el;
        sb.push_back(e);
    endtask

    // Collects one response; observations are returned, the callers compare.
    task automatic wait_rsp(input logic early_ready, output logic [31:0] d, output logic t,
                            output int lat, output logic [2:0] c1, output logic b1,
                            output logic brest);
        lat = 0; c1 = '0; b1 = 1'b0; brest = 1'b0;
        rsp_ready = early_ready;
        do begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                c1 = alu_cntrl;
                b1 = alu_br_en;
            end else begin
                brest |= alu_br_en;
            end
        end while (!rsp_valid && lat < 100);
        d = rsp_data;
        t = rsp_taken;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++;
        if ({rsp_valid, rsp_taken, req_ready} !== 3'b000 || rsp_data !== 32'd0)
            $display("FAIL reset_rsp: valid=%0b taken=%0b ready=%0b data=%h required 0", rsp_valid, rsp_taken, req_ready, rsp_data);
        else n_pass++;
        n_checks++;
        if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_cntrl !== 3'd0 || alu_br_en !== 1'b0)
            $display("FAIL reset_alu: in1=%h in2=%h cntrl=%0d br_en=%0b required 0", alu_in1, alu_in2, alu_cntrl, alu_br_en);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 1'b1) $display("FAIL reset_release_ready: got %0b required 1", req_ready);
        else n_pass++;
    endtask

    task automatic test_add();
        logic [31:0] d; logic t; int lat; logic [2:0] c1; logic b1, br; exp_t e;
        send(3'd0, 32'd7, -32'sd3, 32'd4, 1'b0, 2);
        wait_rsp(1'b1, d, t, lat, c1, b1, br);
        e = sb.pop_front();
        n_checks++; if (d !== e.data) $display("FAIL add_data: got %h required %h", d, e.data); else n_pass++;
        n_checks++; if (t !== e.taken) $display("FAIL add_taken: got %0b required %0b", t, e.taken); else n_pass++;
        n_checks++; if (lat !== e.lat) $display("FAIL add_latency: got %0d required %0d", lat, e.lat); else n_pass++;
        n_checks++; if (c1 !== 3'b000 || b1 !== 1'b0) $display("FAIL add_cntrl: cntrl=%0d br_en=%0b required 0/0", c1, b1); else n_pass++;
    endtask

    task automatic test_sub_xor();
        logic [31:0] d; logic t; int lat; logic [2:0] c1; logic b1, br; exp_t e;
        send(3'd1, 32'h8000_0000, 32'd1, 32'h7FFF_FFFF, 1'b0, 2);
        wait_rsp(1'b0, d, t, lat, c1, b1, br);
        e = sb.pop_front();
        n_checks++; if (d !== e.data || lat !== e.lat) $display("FAIL sub_wrap: data=%h lat=%0d required %h/%0d", d, lat, e.data, e.lat); else n_pass++;
        send(3'd2, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'hF0F0_0F0F, 1'b0, 2);
        wait_rsp(1'b0, d, t, lat, c1, b1, br);
        e = sb.pop_front();
        n_checks++; if (d !== e.data || c1 !== 3'b010) $display("FAIL xor: data=%h cntrl=%0d required %h/2", d, c1, e.data); else n_pass++;
    endtask

    task automatic test_compare();
        logic [31:0] d; logic t; int lat; logic [2:0] c1; logic b1, br; exp_t e;
        logic [2:0]  ops[3]  = '{3'd3, 3'd5, 3'd4};
        logic [31:0] as[3]   = '{32'hFFFF_FFFF, 32'd5, 32'd5};
        logic [31:0] bs[3]   = '{32'd1, 32'd5, 32'd5};
        logic [31:0] eds[3]  = '{32'd1, 32'd0, 32'd0};
        logic        ets[3]  = '{1'b0, 1'b1, 1'b0};
        logic        ebr[3]  = '{1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 3; i++) begin
            send(ops[i], as[i], bs[i], eds[i], ets[i], 2);
            wait_rsp(1'b0, d, t, lat, c1, b1, br);
            e = sb.pop_front();
            n_checks++; if (d !== e.data) $display("FAIL cmp%0d_data: got %h required %h", i, d, e.data); else n_pass++;
            n_checks++; if (t !== e.taken) $display("FAIL cmp%0d_taken: got %0b required %0b", i, t, e.taken); else n_pass++;
            n_checks++; if (b1 !== ebr[i] || br !== 1'b0) $display("FAIL cmp%0d_br_en: exec=%0b other=%0b required %0b/0", i, b1, br, ebr[i]); else n_pass++;
        end
    endtask

    task automatic test_reserved();
        logic [31:0] d; logic t; int lat; logic [2:0] c1; logic b1, br; exp_t e;
        send(3'd7, 32'd5, 32'd3, 32'd0, 1'b0, 2);
        wait_rsp(1'b0, d, t, lat, c1, b1, br);
        e = sb.pop_front();
        n_checks++; if (d !== e.data || t !== e.taken || c1 !== 3'd7) $display("FAIL reserved: data=%h taken=%0b cntrl=%0d required 0/0/7", d, t, c1); else n_pass++;
    endtask

    task automatic test_mul();
        logic [31:0] d; logic t; int lat; logic [2:0] c1; logic b1, br; exp_t e;
        logic [31:0] as[3]  = '{-32'sd6, 32'h0001_0000, 32'hFFFF_FFFF};
        logic [31:0] bs[3]  = '{32'd7, 32'h0001_0000, 32'hFFFF_FFFF};
        logic [31:0] eds[3] = '{32'hFFFF_FFD6, 32'd0, 32'd1};
        for (int i = 0; i < 3; i++) begin
            send(3'd6, as[i], bs[i], eds[i], 1'b0, 33);
            wait_rsp(1'b0, d, t, lat, c1, b1, br);
            e = sb.pop_front();
            n_checks++; if (d !== e.data || t !== e.taken) $display("FAIL mul%0d_data: got %h/%0b required %h/0", i, d, t, e.data); else n_pass++;
            n_checks++; if (lat !== e.lat || c1 !== 3'd0) $display("FAIL mul%0d_latency: lat=%0d cntrl=%0d required %0d/0", i, lat, c1, e.lat); else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d, d0; logic t, t0; int lat; logic [2:0] c1; logic b1, br; exp_t e;
        logic stable, rdy_seen;
        send(3'd0, 32'd10, 32'd20, 32'd30, 1'b0, 2);
        @(negedge clk);
        req_valid = 1'b1; req_op = 3'd1; req_a = 32'd9; req_b = 32'd4;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        d0 = rsp_data; t0 = rsp_taken;
        stable = 1'b1; rdy_seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            stable &= (rsp_data === d0) && (rsp_taken === t0) && (rsp_valid === 1'b1);
            rdy_seen |= (req_ready !== 1'b0);
        end
        e = sb.pop_front();
        n_checks++; if (d0 !== e.data || t0 !== e.taken) $display("FAIL bp_first_data: got %h/%0b required %h/%0b", d0, t0, e.data, e.taken); else n_pass++;
        n_checks++; if (stable !== 1'b1) $display("FAIL bp_stable: got %0b required 1", stable); else n_pass++;
        n_checks++; if (rdy_seen !== 1'b0) $display("FAIL bp_req_ready: seen %0b required 0", rdy_seen); else n_pass++;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) $display("FAIL bp_after_handshake: valid=%0b ready=%0b required 0/1", rsp_valid, req_ready); else n_pass++;
        @(posedge clk);
        #1 req_valid = 1'b0;
        e.data = 32'd5; e.taken = 1'b0; e.lat = 2;
        sb.push_back(e);
        wait_rsp(1'b0, d, t, lat, c1, b1, br);
        e = sb.pop_front();
        n_checks++; if (d !== e.data || lat !== e.lat) $display("FAIL bp_second: data=%h lat=%0d required %h/%0d", d, lat, e.data, e.lat); else n_pass++;
    endtask

    task automatic test_reset_mid_mul();
        logic [31:0] d; logic t; int lat; logic [2:0] c1; logic b1, br; exp_t e;
        logic spurious;
        send(3'd6, -32'sd6, 32'd7, 32'hFFFF_FFD6, 1'b0, 33);
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0 || rsp_data !== 32'd0) $display("FAIL rst_mul_outputs: valid=%0b ready=%0b data=%h required 0/0/0", rsp_valid, req_ready, rsp_data); else n_pass++;
        n_checks++; if (alu_in1 !== 32'd0 || alu_in2 !== 32'd0 || alu_br_en !== 1'b0) $display("FAIL rst_mul_alu: in1=%h in2=%h br_en=%0b required 0", alu_in1, alu_in2, alu_br_en); else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        void'(sb.pop_front());
        rsp_ready = 1'b1;
        spurious = 1'b0;
        repeat (40) begin
            @(negedge clk);
            spurious |= (rsp_valid !== 1'b0);
        end
        rsp_ready = 1'b0;
        n_checks++; if (spurious !== 1'b0) $display("FAIL rst_mul_no_response: got %0b required 0", spurious); else n_pass++;
        send(3'd0, 32'd1, 32'd1, 32'd2, 1'b0, 2);
        wait_rsp(1'b0, d, t, lat, c1, b1, br);
        e = sb.pop_front();
        n_checks++; if (d !== e.data || lat !== e.lat) $display("FAIL rst_mul_followup: data=%h lat=%0d required %h/%0d", d, lat, e.data, e.lat); else n_pass++;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_op    = 3'd0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        test_reset();
        test_add();
        test_sub_xor();
        test_compare();
        test_reserved();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
